// File: rtl/decode_stage_p.sv
// Decode stage: register file, ID/EX register, load-use stall and two-word immediate sequencer.
// Optional DECODE_BYPASS_EN: same-cycle WB write-through onto the src/dst read ports.
module decode_stage_p #(
  parameter int W         = 16,
  parameter int NREG      = 8,
  parameter int CW        = 13,
  parameter int MEMRD_BIT = 12,
  localparam int AW       = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  instr,
  output logic [5:0]    opcode,
  input  logic [CW-1:0] ctrl_in,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  output logic          stall,
  output logic          ex_valid,
  output logic [CW-1:0] ex_ctrl,
  output logic [W-1:0]  ex_rsrc,
  output logic [W-1:0]  ex_rdst,
  output logic [AW-1:0] ex_src,
  output logic [AW-1:0] ex_dst,
  output logic [W-1:0]  ex_imm
);

  typedef enum logic {IDLE, IMM} state_t;

  state_t        state;
  logic [W-1:0]  regs [NREG];
  logic [AW-1:0] src, dst;
  logic [W-1:0]  rd_src, rd_dst;
  logic          hazard;

  logic [AW-1:0] lat_src, lat_dst;
  logic [CW-1:0] lat_ctrl;
  logic [W-1:0]  lat_rsrc, lat_rdst;

  assign opcode = instr[W-1 -: 6];
  assign src    = instr[W-7 -: AW];
  assign dst    = instr[W-7-AW -: AW];

`ifdef DECODE_BYPASS_EN
  assign rd_src = (wb_en && wb_addr == src) ? wb_data : regs[src];
  assign rd_dst = (wb_en && wb_addr == dst) ? wb_data : regs[dst];
`else
  assign rd_src = regs[src];
  assign rd_dst = regs[dst];
`endif

  // Immediate words are consumed in IMM, so only IDLE can see a load-use hazard.
  assign hazard = (state == IDLE) && in_valid && ex_valid && ex_ctrl[MEMRD_BIT] &&
                  ((ex_dst == src) || (ex_dst == dst));
  assign stall  = hazard && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rsrc  <= '0;
      ex_rdst  <= '0;
      ex_src   <= '0;
      ex_dst   <= '0;
      ex_imm   <= '0;
      lat_src  <= '0;
      lat_dst  <= '0;
      lat_ctrl <= '0;
      lat_rsrc <= '0;
      lat_rdst <= '0;
    end else if (flush) begin
      state    <= IDLE;
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !hazard) begin
            if (opcode[5]) begin
              lat_src  <= src;
              lat_dst  <= dst;
              lat_ctrl <= ctrl_in;
              lat_rsrc <= rd_src;
              lat_rdst <= rd_dst;
              state    <= IMM;
              ex_valid <= 1'b0;
              ex_ctrl  <= '0;
            end else begin
              ex_valid <= 1'b1;
              ex_ctrl  <= ctrl_in;
              ex_rsrc  <= rd_src;
              ex_rdst  <= rd_dst;
              ex_src   <= src;
              ex_dst   <= dst;
              ex_imm   <= '0;
            end
          end else begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
          end
        end
        IMM: begin
          if (in_valid) begin
            ex_valid <= 1'b1;
            ex_ctrl  <= lat_ctrl;
            ex_rsrc  <= lat_rsrc;
            ex_rdst  <= lat_rdst;
            ex_src   <= lat_src;
            ex_dst   <= lat_dst;
            ex_imm   <= instr;
            state    <= IDLE;
          end else begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          ex_valid <= 1'b0;
          ex_ctrl  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: expected ID/EX contents are queued per step and checked after the edge.
module tb_decode_stage_p;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, wb_en;
  logic [15:0] instr, wb_data;
  logic [12:0] ctrl_in;
  logic [2:0]  wb_addr;
  logic [5:0]  opcode;
  logic        stall, ex_valid;
  logic [12:0] ex_ctrl;
  logic [15:0] ex_rsrc, ex_rdst, ex_imm;
  logic [2:0]  ex_src, ex_dst;

  int errors = 0;
  int checks = 0;

  localparam logic [12:0] C_ALU = 13'h0025;
  localparam logic [12:0] C_LD  = 13'h1011;
`ifdef DECODE_BYPASS_EN
  localparam logic [15:0] BYP_RS = 16'hBEEF;
`else
  localparam logic [15:0] BYP_RS = 16'h0000;
`endif

  typedef struct packed {
    logic        v;
    logic [12:0] c;
    logic [15:0] rs, rd;
    logic [2:0]  s, d;
    logic [15:0] imm;
  } exp_t;

  exp_t sb[$];

  decode_stage_p dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .opcode(opcode),
    .ctrl_in(ctrl_in), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_rsrc(ex_rsrc), .ex_rdst(ex_rdst), .ex_src(ex_src), .ex_dst(ex_dst),
    .ex_imm(ex_imm)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [5:0] op, input logic [2:0] s, input logic [2:0] d);
    return {op, s, d, 4'b0000};
  endfunction

  function automatic exp_t bub();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t ent(input logic [12:0] c, input logic [15:0] rs, input logic [15:0] rd,
                               input logic [2:0] s, input logic [2:0] d, input logic [15:0] imm);
    exp_t e;
    e.v = 1'b1; e.c = c; e.rs = rs; e.rd = rd; e.s = s; e.d = d; e.imm = imm;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, check combinational outputs, then the registered ID/EX result.
  task automatic step(input logic v, input logic [15:0] ins, input logic [12:0] c, input logic fl,
                      input logic we, input logic [2:0] wa, input logic [15:0] wd,
                      input logic est, input exp_t e);
    exp_t x;
    in_valid = v; instr = ins; ctrl_in = c; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #2;
    check("stall", {31'd0, stall}, {31'd0, est});
    check("opcode", {26'd0, opcode}, {26'd0, ins[15:10]});
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("ex_valid", {31'd0, ex_valid}, {31'd0, x.v});
    check("ex_ctrl", {19'd0, ex_ctrl}, {19'd0, x.c});
    if (x.v) begin
      check("ex_rsrc", {16'd0, ex_rsrc}, {16'd0, x.rs});
      check("ex_rdst", {16'd0, ex_rdst}, {16'd0, x.rd});
      check("ex_src", {29'd0, ex_src}, {29'd0, x.s});
      check("ex_dst", {29'd0, ex_dst}, {29'd0, x.d});
      check("ex_imm", {16'd0, ex_imm}, {16'd0, x.imm});
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; instr = mk(6'h01, 3'd3, 3'd5); ctrl_in = C_LD;
    flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_ctrl", {19'd0, ex_ctrl}, 32'd0);
    check("rst_ex_rsrc", {16'd0, ex_rsrc}, 32'd0);
    check("rst_ex_rdst", {16'd0, ex_rdst}, 32'd0);
    check("rst_ex_imm", {16'd0, ex_imm}, 32'd0);
    check("rst_ex_srcdst", {26'd0, ex_src, ex_dst}, 32'd0);
    rst = 1'b0;

    // Plain decode after reset, then same-cycle write/read of r3 and re-decode
    step(1, mk(6'h01, 3, 5), C_ALU, 0, 0, 0, 16'h0, 0, ent(C_ALU, 16'h0, 16'h0, 3, 5, 16'h0));
    step(1, mk(6'h01, 3, 5), C_ALU, 0, 1, 3, 16'hBEEF, 0, ent(C_ALU, BYP_RS, 16'h0, 3, 5, 16'h0));
    step(1, mk(6'h01, 3, 5), C_ALU, 0, 0, 0, 16'h0, 0, ent(C_ALU, 16'hBEEF, 16'h0, 3, 5, 16'h0));
    step(0, mk(6'h01, 0, 0), C_ALU, 0, 1, 2, 16'h0222, 0, bub());

    // Load to r2, dependent instruction stalls once, then issues
    step(1, mk(6'h02, 3, 2), C_LD, 0, 0, 0, 16'h0, 0, ent(C_LD, 16'hBEEF, 16'h0222, 3, 2, 16'h0));
    step(1, mk(6'h01, 2, 4), C_ALU, 0, 0, 0, 16'h0, 1, bub());
    step(1, mk(6'h01, 2, 4), C_ALU, 0, 1, 1, 16'h0111, 0, ent(C_ALU, 16'h0222, 16'h0, 2, 4, 16'h0));

    // Two-word instruction with a two-cycle gap before the immediate
    step(1, mk(6'h21, 1, 3), 13'h0055, 0, 0, 0, 16'h0, 0, bub());
    step(0, 16'h0, C_ALU, 0, 1, 1, 16'h9999, 0, bub());
    step(0, 16'h0, C_ALU, 0, 0, 0, 16'h0, 0, bub());
    step(1, 16'h1234, C_ALU, 0, 0, 0, 16'h0, 0, ent(13'h0055, 16'h0111, 16'hBEEF, 1, 3, 16'h1234));

    // Flush while in IMM: next word is decoded as an opcode
    step(1, mk(6'h22, 1, 1), 13'h0AAA, 0, 0, 0, 16'h0, 0, bub());
    step(1, mk(6'h01, 3, 5), C_ALU, 1, 0, 0, 16'h0, 0, bub());
    step(1, mk(6'h01, 3, 5), C_ALU, 0, 0, 0, 16'h0, 0, ent(C_ALU, 16'hBEEF, 16'h0, 3, 5, 16'h0));

    // Flush during a load-use hazard (dst-field match)
    step(1, mk(6'h02, 3, 5), C_LD, 0, 0, 0, 16'h0, 0, ent(C_LD, 16'hBEEF, 16'h0, 3, 5, 16'h0));
    step(1, mk(6'h01, 0, 5), C_ALU, 1, 0, 0, 16'h0, 0, bub());
    step(1, mk(6'h01, 0, 5), C_ALU, 0, 0, 0, 16'h0, 0, ent(C_ALU, 16'h0, 16'h0, 0, 5, 16'h0));

    // Reset while in IMM drops the pending instruction and clears the register file
    step(1, mk(6'h21, 3, 2), C_ALU, 0, 0, 0, 16'h0, 0, bub());
    rst = 1'b1; in_valid = 1'b1; instr = 16'h1234;
    #2;
    check("stall_in_rst", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_imm_ex_valid", {31'd0, ex_valid}, 32'd0);
    rst = 1'b0;
    step(1, mk(6'h01, 3, 2), C_ALU, 0, 0, 0, 16'h0, 0, ent(C_ALU, 16'h0, 16'h0, 3, 2, 16'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
